// File: rtl/clint_vec.sv
// Core-local interrupt controller: trap/MRET sequencing with CSR writes and redirect.
// Optional vectored mtvec dispatch for async traps under `CLINT_VEC_VECTOR_EN.
module clint_vec #(
    parameter int NUM_INT  = 8,
    parameter int MTIP_IDX = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] int_req_i,
    input  logic [NUM_INT-1:0] int_en_i,
    input  logic               global_int_en_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic               div_started_i,
    input  logic [31:0]        csr_mtvec,
    input  logic [31:0]        csr_mepc,
    input  logic [31:0]        csr_mstatus,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [31:0]        waddr_o,
    output logic [31:0]        data_o,
    output logic               int_assert_o,
    output logic [31:0]        int_addr_o,
    output logic [NUM_INT-1:0] int_ack_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MSTATUS,
        S_MCAUSE,
        S_ASSERT,
        S_MRET
    } state_t;

    state_t             state_q;
    logic [NUM_INT-1:0] pend_q, pend_d;
    logic [NUM_INT-1:0] ack_q;
    logic [31:0]        epc_q;
    logic [31:0]        cause_q;
    logic               we_q;
    logic [31:0]        waddr_q;
    logic [31:0]        data_q;
    logic               assert_q;
    logic [31:0]        iaddr_q;

    logic [NUM_INT-1:0] elig;
    logic [4:0]         win;
    logic               is_sync;
    logic               sync_ev;
    logic               async_ev;
    logic               mret_ev;
    logic               idle;
    logic [31:0]        ret_sync;
    logic [31:0]        ret_async;
    logic [31:0]        cause_sync;
    logic [31:0]        cause_async;
    logic [31:0]        base;
    logic [31:0]        trap_addr;
    logic [31:0]        mst_trap;
    logic [31:0]        mst_mret;

    assign elig = pend_q & int_en_i;

    always_comb begin
        win = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (elig[i]) win = 5'(i);
        end
    end

    assign idle     = (state_q == S_IDLE);
    assign is_sync  = (inst_i == INST_ECALL) || (inst_i == INST_EBREAK);
    // A sync trap during a divide blocks every event until the divide ends
    assign sync_ev  = idle && is_sync && !div_started_i;
    assign async_ev = idle && !is_sync && (|elig) && global_int_en_i;
    assign mret_ev  = idle && !is_sync && !async_ev && (inst_i == INST_MRET);

    assign hold_flag_o = sync_ev || async_ev || mret_ev || !idle || assert_q;

    assign ret_sync  = jump_flag_i ? jump_addr_i - 32'd4 : inst_addr_i;
    assign ret_async = jump_flag_i   ? jump_addr_i :
                       div_started_i ? inst_addr_i - 32'd4 : inst_addr_i;

    assign cause_sync  = (inst_i == INST_ECALL) ? 32'd11 : 32'd3;
    assign cause_async = (win == 5'(MTIP_IDX)) ? 32'h8000_0007 :
                         {1'b1, 31'(32'd16 + 32'(win))};

    assign base = {csr_mtvec[31:2], 2'b00};

`ifdef CLINT_VEC_VECTOR_EN
    assign trap_addr = (cause_q[31] && csr_mtvec[1:0] == 2'b01) ?
                       base + {cause_q[29:0], 2'b00} : base;
`else
    assign trap_addr = base;
`endif

    assign mst_trap = (csr_mstatus & ~32'h88) | {24'd0, csr_mstatus[3], 7'd0};
    assign mst_mret = (csr_mstatus & ~32'h88) | 32'h80 |
                      {28'd0, csr_mstatus[7], 3'd0};

    assign pend_d = (pend_q | int_req_i) & ~ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            ack_q    <= '0;
            epc_q    <= '0;
            cause_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            data_q   <= '0;
            assert_q <= 1'b0;
            iaddr_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            ack_q    <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            data_q   <= '0;
            assert_q <= 1'b0;
            iaddr_q  <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (sync_ev) begin
                        epc_q   <= ret_sync;
                        cause_q <= cause_sync;
                        state_q <= S_MEPC;
                    end else if (async_ev) begin
                        epc_q   <= ret_async;
                        cause_q <= cause_async;
                        ack_q   <= NUM_INT'(1) << win;
                        state_q <= S_MEPC;
                    end else if (mret_ev) begin
                        state_q <= S_MRET;
                    end
                end
                S_MEPC: begin
                    we_q    <= 1'b1;
                    waddr_q <= 32'h341;
                    data_q  <= epc_q;
                    state_q <= S_MSTATUS;
                end
                S_MSTATUS: begin
                    we_q    <= 1'b1;
                    waddr_q <= 32'h300;
                    data_q  <= mst_trap;
                    state_q <= S_MCAUSE;
                end
                S_MCAUSE: begin
                    we_q    <= 1'b1;
                    waddr_q <= 32'h342;
                    data_q  <= cause_q;
                    state_q <= S_ASSERT;
                end
                S_ASSERT: begin
                    assert_q <= 1'b1;
                    iaddr_q  <= trap_addr;
                    state_q  <= S_IDLE;
                end
                S_MRET: begin
                    we_q     <= 1'b1;
                    waddr_q  <= 32'h300;
                    data_q   <= mst_mret;
                    assert_q <= 1'b1;
                    iaddr_q  <= csr_mepc;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign data_o       = data_q;
    assign int_assert_o = assert_q;
    assign int_addr_o   = iaddr_q;
    assign int_ack_o    = ack_q;

endmodule

// File: tb/tb_clint_vec.sv
// Scoreboard bench for clint_vec: expected CSR writes, redirects and acks
// are queued at stimulus time and popped when the DUT emits them.
module tb_clint_vec;

    localparam int N = 8;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] int_req_i, int_en_i;
    logic         global_int_en_i;
    logic [31:0]  inst_i, inst_addr_i, jump_addr_i;
    logic         jump_flag_i, div_started_i;
    logic [31:0]  csr_mtvec, csr_mepc, csr_mstatus;
    logic         hold_flag_o, we_o, int_assert_o;
    logic [31:0]  waddr_o, data_o, int_addr_o;
    logic [N-1:0] int_ack_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] wq[$];
    logic [31:0] aq[$];
    logic [N-1:0] kq[$];

    clint_vec #(.NUM_INT(N), .MTIP_IDX(0)) dut (
        .clk(clk), .rst(rst),
        .int_req_i(int_req_i), .int_en_i(int_en_i),
        .global_int_en_i(global_int_en_i),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .div_started_i(div_started_i),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .csr_mstatus(csr_mstatus),
        .hold_flag_o(hold_flag_o), .we_o(we_o),
        .waddr_o(waddr_o), .data_o(data_o),
        .int_assert_o(int_assert_o), .int_addr_o(int_addr_o),
        .int_ack_o(int_ack_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] mst,
                             input logic [31:0] cause, input logic [31:0] tgt);
        wq.push_back({32'h341, epc});
        wq.push_back({32'h300, mst});
        wq.push_back({32'h342, cause});
        aq.push_back(tgt);
    endtask

    always @(negedge clk) begin
        if (we_o) begin
            if (wq.size() == 0) chk("we_unexpected", {waddr_o, data_o}, 64'd0);
            else begin
                logic [63:0] e;
                e = wq.pop_front();
                chk("csr_write", {waddr_o, data_o}, e);
            end
        end
        if (int_assert_o) begin
            if (aq.size() == 0) chk("assert_unexpected", 64'(int_addr_o), 64'd0);
            else begin
                logic [31:0] a;
                a = aq.pop_front();
                chk("int_addr", 64'(int_addr_o), 64'(a));
            end
        end
        if (int_ack_o != '0) begin
            if (kq.size() == 0) chk("ack_unexpected", 64'(int_ack_o), 64'd0);
            else begin
                logic [N-1:0] k;
                k = kq.pop_front();
                chk("int_ack", 64'(int_ack_o), 64'(k));
            end
        end
    end

    initial begin
        logic [31:0] vec_exp;
        rst = 1'b1;
        int_req_i = '0; int_en_i = '1; global_int_en_i = 1'b1;
        inst_i = NOP; inst_addr_i = 32'h0;
        jump_flag_i = 1'b0; jump_addr_i = 32'h0; div_started_i = 1'b0;
        csr_mtvec = 32'h200; csr_mepc = 32'h0; csr_mstatus = 32'h8;
        repeat (2) tick();
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_assert", 64'(int_assert_o), 64'd0);
        chk("rst_ack", 64'(int_ack_o), 64'd0);
        rst = 1'b0;
        #1 chk("idle_hold", 64'(hold_flag_o), 64'd0);

        // ECALL at 0x100
        inst_i = ECALL; inst_addr_i = 32'h100;
        push_trap(32'h100, 32'h80, 32'd11, 32'h200);
        #1 chk("ecall_hold", 64'(hold_flag_o), 64'd1);
        tick();
        inst_i = NOP;
        repeat (3) tick();
        chk("ecall_t4_noassert", 64'(int_assert_o), 64'd0);
        tick();
        chk("ecall_t5_assert", 64'(int_assert_o), 64'd1);
        chk("ecall_t5_hold", 64'(hold_flag_o), 64'd1);
        tick();
        chk("ecall_done_hold", 64'(hold_flag_o), 64'd0);

        // two simultaneous sources: 3 then 5
        inst_addr_i = 32'h400;
        kq.push_back(8'h08);
        push_trap(32'h400, 32'h80, 32'h8000_0013, 32'h200);
        kq.push_back(8'h20);
        push_trap(32'h400, 32'h80, 32'h8000_0015, 32'h200);
        int_req_i = 8'h28;
        tick();
        int_req_i = '0;
        repeat (14) tick();

        // masked source stays pending until enabled
        int_en_i = 8'hBF; inst_addr_i = 32'h700;
        int_req_i = 8'h40;
        tick();
        int_req_i = '0;
        tick();
        chk("masked_hold", 64'(hold_flag_o), 64'd0);
        kq.push_back(8'h40);
        push_trap(32'h700, 32'h80, 32'h8000_0016, 32'h200);
        int_en_i = '1;
        #1 chk("unmask_hold", 64'(hold_flag_o), 64'd1);
        repeat (8) tick();

        // timer source with mtvec mode 01, taken over a jump
        csr_mtvec = 32'h1001;
        jump_flag_i = 1'b1; jump_addr_i = 32'h500;
`ifdef CLINT_VEC_VECTOR_EN
        vec_exp = 32'h101C;
`else
        vec_exp = 32'h1000;
`endif
        kq.push_back(8'h01);
        push_trap(32'h500, 32'h80, 32'h8000_0007, vec_exp);
        int_req_i = 8'h01;
        tick();
        int_req_i = '0;
        repeat (8) tick();

        // sync trap under a jump ignores vectoring
        inst_i = ECALL; jump_addr_i = 32'h600;
        push_trap(32'h5FC, 32'h80, 32'd11, 32'h1000);
        tick();
        inst_i = NOP; jump_flag_i = 1'b0;
        repeat (7) tick();

        // EBREAK blocked by divide
        csr_mtvec = 32'h200;
        inst_i = EBREAK; inst_addr_i = 32'h60; div_started_i = 1'b1;
        #1 chk("ebreak_div_hold", 64'(hold_flag_o), 64'd0);
        repeat (3) tick();
        chk("ebreak_div_hold2", 64'(hold_flag_o), 64'd0);
        push_trap(32'h60, 32'h80, 32'd3, 32'h200);
        div_started_i = 1'b0;
        #1 chk("ebreak_go_hold", 64'(hold_flag_o), 64'd1);
        tick();
        inst_i = NOP;
        repeat (7) tick();

        // async during divide at 0x80
        inst_addr_i = 32'h80; div_started_i = 1'b1;
        kq.push_back(8'h04);
        push_trap(32'h7C, 32'h80, 32'h8000_0012, 32'h200);
        int_req_i = 8'h04;
        tick();
        int_req_i = '0;
        repeat (8) tick();
        div_started_i = 1'b0;

        // MRET
        csr_mstatus = 32'h80; csr_mepc = 32'h300; inst_i = MRET;
        wq.push_back({32'h300, 32'h88});
        aq.push_back(32'h300);
        #1 chk("mret_hold", 64'(hold_flag_o), 64'd1);
        tick();
        inst_i = NOP;
        tick();
        chk("mret_assert", 64'(int_assert_o), 64'd1);
        tick();
        chk("mret_done_hold", 64'(hold_flag_o), 64'd0);

        // reset in MSTATUS state aborts the trap and clears pend
        csr_mstatus = 32'h8; global_int_en_i = 1'b0;
        int_req_i = 8'h02;
        tick();
        int_req_i = '0;
        inst_i = ECALL; inst_addr_i = 32'h100;
        wq.push_back({32'h341, 32'h100});
        tick();
        inst_i = NOP;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_we", 64'(we_o), 64'd0);
        chk("rst_mid_waddr", 64'(waddr_o), 64'd0);
        chk("rst_mid_data", 64'(data_o), 64'd0);
        chk("rst_mid_assert", 64'(int_assert_o), 64'd0);
        chk("rst_mid_addr", 64'(int_addr_o), 64'd0);
        chk("rst_mid_ack", 64'(int_ack_o), 64'd0);
        rst = 1'b0; global_int_en_i = 1'b1;
        #1 chk("rst_pend_clear", 64'(hold_flag_o), 64'd0);
        repeat (6) tick();

        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("aq_empty", 64'(aq.size()), 64'd0);
        chk("kq_empty", 64'(kq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_vec.md
CLINT_VEC -- requirements
Module: clint_vec

Interface
REQ-001 SHALL have parameter NUM_INT, default 8, number of async interrupt sources (legal 1..16).
REQ-002 SHALL have parameter MTIP_IDX, default 0, index of the timer source within int_req_i.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- int_req_i  in  NUM_INT  level interrupt requests
- int_en_i  in  NUM_INT  per-source enable (mie mask)
- global_int_en_i  in  1  mstatus.MIE
- inst_i  in  32  instruction in decode
- inst_addr_i  in  32  its address
- jump_flag_i  in  1  ex-stage jump taken
- jump_addr_i  in  32  jump target
- div_started_i  in  1  divide in progress
- csr_mtvec, csr_mepc, csr_mstatus  in  32 each  current CSR values
- hold_flag_o  out  1  pipeline hold request
- we_o  out  1  CSR write enable
- waddr_o  out  32  CSR write address
- data_o  out  32  CSR write data
- int_assert_o  out  1  redirect pulse to ex
- int_addr_o  out  32  redirect target
- int_ack_o  out  NUM_INT  one-hot acknowledge pulse

Function
REQ-004 SHALL keep pend[NUM_INT]: bit set in any cycle int_req_i[i]=1; bit cleared in the cycle its int_ack_o[i] pulses (clear wins over set that cycle).
REQ-005 SHALL form eligible = pend & int_en_i; winner = lowest eligible index.
REQ-006 SHALL evaluate events only in state IDLE, priority: ECALL/EBREAK (only if div_started_i=0; else no event) > async (eligible!=0 and global_int_en_i=1) > MRET (32'h30200073).
REQ-007 SHALL run FSM IDLE->MEPC->MSTATUS->MCAUSE->ASSERT->IDLE for traps and IDLE->MRET->IDLE for MRET, one state per cycle.
REQ-008 On trap accept at edge T (event in IDLE): capture return address and cause; int_ack_o[winner] SHALL pulse in cycle T+1 for async only.
REQ-009 Return address SHALL be: sync: jump_flag_i ? jump_addr_i-4 : inst_addr_i; async: jump_flag_i ? jump_addr_i : div_started_i ? inst_addr_i-4 : inst_addr_i.
REQ-010 Cause SHALL be: ECALL 11, EBREAK 3, async {1'b1, 31'(16+winner)}, except winner==MTIP_IDX gives 32'h80000007.
REQ-011 we_o/waddr_o/data_o SHALL be registered from state: MEPC writes 0x341=return address; MSTATUS writes 0x300 with bit7<=csr_mstatus[3], bit3<=0, others kept; MCAUSE writes 0x342=cause.
REQ-012 MRET state SHALL write 0x300 with bit3<=csr_mstatus[7], bit7<=1, and pulse int_assert_o with int_addr_o=csr_mepc the following cycle.
REQ-013 ASSERT state SHALL produce, the following cycle, int_assert_o=1 for exactly one cycle with int_addr_o per Configuration.
REQ-014 hold_flag_o SHALL be 1 whenever an event is detected in IDLE or FSM not IDLE, including the int_assert_o cycle.
REQ-015 New requests arriving mid-sequence SHALL only pend; a sync instruction mid-sequence SHALL be ignored (pipeline held).
REQ-016 When not writing, we_o=0, waddr_o=0, data_o=0; when not asserting, int_assert_o=0, int_addr_o=0.

Reset
REQ-017 rst=1 at an edge SHALL force FSM=IDLE, pend=0, cause=0, captured address=0, all outputs 0, aborting any sequence with no partial CSR writes after that edge.

Configuration
REQ-018 Macro CLINT_VEC_VECTOR_EN defined: async trap with csr_mtvec[1:0]==2'b01 SHALL give int_addr_o={csr_mtvec[31:2],2'b00}+4*cause[30:0]; sync traps and mode 00 use the base.
REQ-019 Macro undefined: int_addr_o SHALL always be {csr_mtvec[31:2],2'b00}; mtvec mode bits ignored.

Verification
REQ-020 ECALL at 0x100, no jump, mtvec=0x200 -> writes 0x341=0x100, 0x300 (MIE=0, MPIE=old MIE), 0x342=11; int_assert_o, int_addr_o=0x200 five cycles after accept.
REQ-021 int_req_i[3] and [5] together, both enabled, MIE=1 -> source 3 taken, int_ack_o=8'h08, mcause=0x80000013; source 5 taken after returning to IDLE.
REQ-022 Vectored (macro on) mtvec=0x1001, timer source -> int_addr_o=0x101C; macro off -> 0x1000.
REQ-023 EBREAK with div_started_i=1 -> no event until div_started_i=0; async during divide at 0x80 -> mepc=0x7C.
REQ-024 MRET with mstatus=0x80, mepc=0x300 -> writes 0x300=0x88; int_addr_o=0x300 pulse.
REQ-025 rst asserted in MSTATUS state -> next cycle all outputs 0, pend=0, no MCAUSE write or assert.
